// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : raster_pkg
//  Purpose  : Shared raster front-end types: default coordinate widths,
//             primitive topology and cull-mode encodings, vertex word layout.
//  Revision : 1.0  initial release
// ============================================================================
package raster_pkg;

    localparam int c_XW  = 16;
    localparam int c_ZW  = 8;
    localparam int c_UVW = 32;

    typedef enum logic [1:0] {
        MODE_LIST     = 2'd0,
        MODE_STRIP    = 2'd1,
        MODE_FAN      = 2'd2,
        MODE_LIST_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        CULL_NONE = 2'd0,
        CULL_CW   = 2'd1,
        CULL_CCW  = 2'd2,
        CULL_ALL  = 2'd3
    } cull_e;

    // Vertex word as it arrives from the FIFO, MSB first.
    typedef struct packed {
        logic signed [c_XW-1:0] x;
        logic signed [c_XW-1:0] y;
        logic [c_ZW-1:0]        z;
        logic [c_UVW-1:0]       u;
        logic [c_UVW-1:0]       v;
    } vertex_t;

endpackage
`default_nettype wire

// File: rtl/cull_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cull_unit
//  Purpose  : Registers the signed doubled area of a screen-space triangle
//             and derives the cull decision from its sign and the cull mode.
//  Revision : 1.0  initial release
// ============================================================================
module cull_unit
    import raster_pkg::*;
#(
    parameter int XW = c_XW
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic [3*XW-1:0] i_x,
    input  logic [3*XW-1:0] i_y,
    input  logic [1:0]      i_cull,
    output logic            o_cull
);

    localparam int c_AW = 2*XW + 3;
    localparam int c_PW = 2*XW + 2;

    logic signed [XW:0]     w_x0, w_x1, w_x2, w_y0, w_y1, w_y2;
    logic signed [XW:0]     w_dx1, w_dx2, w_dy1, w_dy2;
    logic signed [c_PW-1:0] w_p0, w_p1;
    logic signed [c_AW-1:0] w_area;
    logic signed [c_AW-1:0] r_area;

    // Sign-extend every coordinate one bit so the differences cannot overflow.
    always_comb begin
        w_x0   = {i_x[XW-1],   i_x[XW-1:0]};
        w_x1   = {i_x[2*XW-1], i_x[2*XW-1:XW]};
        w_x2   = {i_x[3*XW-1], i_x[3*XW-1:2*XW]};
        w_y0   = {i_y[XW-1],   i_y[XW-1:0]};
        w_y1   = {i_y[2*XW-1], i_y[2*XW-1:XW]};
        w_y2   = {i_y[3*XW-1], i_y[3*XW-1:2*XW]};
        w_dx1  = w_x1 - w_x0;
        w_dx2  = w_x2 - w_x0;
        w_dy1  = w_y1 - w_y0;
        w_dy2  = w_y2 - w_y0;
        w_p0   = c_PW'(w_dx1) * c_PW'(w_dy2);
        w_p1   = c_PW'(w_dx2) * c_PW'(w_dy1);
        w_area = c_AW'(w_p0) - c_AW'(w_p1);
    end

    // Capture the area once per triangle; it then stays put for the decision.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_area <= '0;
        end else if (i_load) begin
            r_area <= w_area;
        end
    end

    // Degenerate triangles go whenever any culling is enabled; otherwise by winding.
    always_comb begin
        o_cull = 1'b0;
        if (r_area == '0) begin
            o_cull = (i_cull != CULL_NONE);
        end else if (r_area[c_AW-1]) begin
            o_cull = (i_cull == CULL_CW) || (i_cull == CULL_ALL);
        end else begin
            o_cull = (i_cull == CULL_CCW) || (i_cull == CULL_ALL);
        end
    end

endmodule
`default_nettype wire

// File: rtl/primitive_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : primitive_assembler
//  Purpose  : Pulls vertices from a FIFO, assembles list/strip/fan triangles,
//             culls by winding and hands surviving triangles to the rasterizer.
//  Revision : 1.0  initial release
// ============================================================================
module primitive_assembler
    import raster_pkg::*;
#(
    parameter int XW  = c_XW,
    parameter int ZW  = c_ZW,
    parameter int UVW = c_UVW,
    parameter int VW  = 2*XW + ZW + 2*UVW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [VW-1:0]    i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_fifo_read,
    input  logic [1:0]       i_mode,
    input  logic [1:0]       i_cull,
    input  logic             i_restart,
    output logic             o_tri_valid,
    input  logic             i_raster_busy,
    output logic [3*XW-1:0]  o_x,
    output logic [3*XW-1:0]  o_y,
    output logic [3*ZW-1:0]  o_z,
    output logic [3*UVW-1:0] o_u,
    output logic [3*UVW-1:0] o_v,
    output logic [15:0]      o_tri_count,
    output logic [15:0]      o_cull_count
);

    // Field MSB positions inside a vertex word {x, y, z, u, v}.
    localparam int c_XM = VW - 1;
    localparam int c_YM = VW - XW - 1;
    localparam int c_ZM = 2*UVW + ZW - 1;
    localparam int c_UM = 2*UVW - 1;
    localparam int c_VM = UVW - 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LATCH  = 3'd1,
        S_AREA   = 3'd2,
        S_DECIDE = 3'd3,
        S_OUT    = 3'd4
    } state_e;

    state_e               r_state, w_state_nxt;
    logic [1:0]           r_count, w_count_inc;
    logic                 r_parity, r_restart_pend;
    mode_e                r_mode;
    logic [2:0][VW-1:0]   r_vtx;
    logic [VW-1:0]        w_t0, w_t1, w_t2;
    logic                 w_strip, w_list, w_swap, w_cull, w_done, w_apply_rst;
    logic [3*XW-1:0]      w_x, w_y, r_x, r_y;
    logic [3*ZW-1:0]      w_z, r_z;
    logic [3*UVW-1:0]     w_u, w_v, r_u, r_v;
    logic [15:0]          r_tri_count, r_cull_count;

    // Output-ordered triangle; odd strip triangles swap slots 0/1 to keep winding.
    always_comb begin
        w_strip     = (r_mode == MODE_STRIP);
        w_list      = (r_mode == MODE_LIST) || (r_mode == MODE_LIST_ALT);
        w_swap      = w_strip && r_parity;
        w_t0        = w_swap ? r_vtx[1] : r_vtx[0];
        w_t1        = w_swap ? r_vtx[0] : r_vtx[1];
        w_t2        = r_vtx[2];
        w_x         = {w_t2[c_XM -: XW],  w_t1[c_XM -: XW],  w_t0[c_XM -: XW]};
        w_y         = {w_t2[c_YM -: XW],  w_t1[c_YM -: XW],  w_t0[c_YM -: XW]};
        w_z         = {w_t2[c_ZM -: ZW],  w_t1[c_ZM -: ZW],  w_t0[c_ZM -: ZW]};
        w_u         = {w_t2[c_UM -: UVW], w_t1[c_UM -: UVW], w_t0[c_UM -: UVW]};
        w_v         = {w_t2[c_VM -: UVW], w_t1[c_VM -: UVW], w_t0[c_VM -: UVW]};
        w_count_inc = (r_count == 2'd3) ? 2'd3 : r_count + 2'd1;
    end

    cull_unit #(
        .XW (XW)
    ) u_cull (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (r_state == S_AREA),
        .i_x     (w_x),
        .i_y     (w_y),
        .i_cull  (i_cull),
        .o_cull  (w_cull)
    );

    // Next-state and strobe decode; outputs forced low while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        o_fifo_read = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (!i_restart && !i_fifo_empty) begin
                    o_fifo_read = i_rst_n;
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                if (i_restart || (w_count_inc != 2'd3)) w_state_nxt = S_FETCH;
                else                                     w_state_nxt = S_AREA;
            end
            S_AREA:   w_state_nxt = S_DECIDE;
            S_DECIDE: begin
                if (w_cull) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (!i_raster_busy) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default:  w_state_nxt = S_FETCH;
        endcase
        o_tri_valid = (r_state == S_OUT) && i_rst_n;
        w_apply_rst = w_done && (r_restart_pend || i_restart);
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_FETCH;
        else          r_state <= w_state_nxt;
    end

    // Vertex storage, topology bookkeeping, output registers and counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count        <= 2'd0;
            r_parity       <= 1'b0;
            r_restart_pend <= 1'b0;
            r_mode         <= MODE_LIST;
            r_vtx          <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_z            <= '0;
            r_u            <= '0;
            r_v            <= '0;
            r_tri_count    <= 16'd0;
            r_cull_count   <= 16'd0;
        end else begin
            case (r_state)
                S_FETCH, S_LATCH: begin
                    if (i_restart) begin
                        r_count        <= 2'd0;
                        r_parity       <= 1'b0;
                        r_restart_pend <= 1'b0;
                    end else if (r_state == S_LATCH) begin
                        if (r_count == 2'd0) r_mode <= mode_e'(i_mode);
                        if (r_count != 2'd3) begin
                            r_vtx[r_count] <= i_fifo_data;
                        end else begin
                            // Strip slides the whole window; fan keeps its hub vertex.
                            if (w_strip) r_vtx[0] <= r_vtx[1];
                            r_vtx[1] <= r_vtx[2];
                            r_vtx[2] <= i_fifo_data;
                        end
                        r_count <= w_count_inc;
                    end
                end
                S_AREA: begin
                    r_x <= w_x;
                    r_y <= w_y;
                    r_z <= w_z;
                    r_u <= w_u;
                    r_v <= w_v;
                    if (i_restart) r_restart_pend <= 1'b1;
                end
                S_DECIDE: begin
                    if (i_restart) r_restart_pend <= 1'b1;
                    if (w_cull)    r_cull_count   <= r_cull_count + 16'd1;
                end
                S_OUT: begin
                    if (i_restart)      r_restart_pend <= 1'b1;
                    if (!i_raster_busy) r_tri_count    <= r_tri_count + 16'd1;
                end
                default: ;
            endcase
            if (w_done) begin
                r_restart_pend <= 1'b0;
                if (w_apply_rst || w_list) r_count <= 2'd0;
                if (w_apply_rst)           r_parity <= 1'b0;
                else if (w_strip)          r_parity <= ~r_parity;
            end
        end
    end

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_z          = r_z;
    assign o_u          = r_u;
    assign o_v          = r_v;
    assign o_tri_count  = r_tri_count;
    assign o_cull_count = r_cull_count;

endmodule
`default_nettype wire

// File: tb/tb_primitive_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_primitive_assembler
//  Purpose  : Directed self-checking bench for primitive_assembler with a
//             FIFO model and an expected-triangle scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_primitive_assembler;
    import raster_pkg::*;

    localparam int XW  = 16;
    localparam int ZW  = 8;
    localparam int UVW = 32;
    localparam int VW  = 2*XW + ZW + 2*UVW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [VW-1:0]    fifo_data = '0;
    logic             fifo_empty;
    logic             fifo_read;
    logic [1:0]       mode, cull;
    logic             restart, raster_busy, tri_valid;
    logic [3*XW-1:0]  o_x, o_y;
    logic [3*ZW-1:0]  o_z;
    logic [3*UVW-1:0] o_u, o_v;
    logic [15:0]      tri_count, cull_count;

    always #5 clk = ~clk;

    primitive_assembler #(.XW(XW), .ZW(ZW), .UVW(UVW), .VW(VW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_fifo_data   (fifo_data),
        .i_fifo_empty  (fifo_empty),
        .o_fifo_read   (fifo_read),
        .i_mode        (mode),
        .i_cull        (cull),
        .i_restart     (restart),
        .o_tri_valid   (tri_valid),
        .i_raster_busy (raster_busy),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_z           (o_z),
        .o_u           (o_u),
        .o_v           (o_v),
        .o_tri_count   (tri_count),
        .o_cull_count  (cull_count)
    );

    typedef struct {
        logic [3*XW-1:0]  x, y;
        logic [3*ZW-1:0]  z;
        logic [3*UVW-1:0] u, v;
        logic [2*XW+2:0]  area;
    } tri_t;

    tri_t    exp_q[$];
    vertex_t vbuf [0:63];
    int      wr_ptr = 0;
    int      rd_ptr = 0;
    int      checks = 0;
    int      errors = 0;

    // FIFO model: data appears the cycle after the read strobe.
    always_comb fifo_empty = (rd_ptr >= wr_ptr);
    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_data <= vbuf[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*XW+2:0] area3(input vertex_t a, input vertex_t b, input vertex_t c);
        longint ax, ay, bx, by, cx, cy, r;
        ax = a.x; ay = a.y; bx = b.x; by = b.y; cx = c.x; cy = c.y;
        r  = (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
        return r[2*XW+2:0];
    endfunction

    function automatic tri_t mk_tri(input vertex_t a, input vertex_t b, input vertex_t c);
        tri_t t;
        t.x    = {c.x, b.x, a.x};
        t.y    = {c.y, b.y, a.y};
        t.z    = {c.z, b.z, a.z};
        t.u    = {c.u, b.u, a.u};
        t.v    = {c.v, b.v, a.v};
        t.area = area3(a, b, c);
        return t;
    endfunction

    function automatic vertex_t mkv(input int x, input int y);
        vertex_t v;
        v.x = 16'(x);
        v.y = 16'(y);
        v.z = 8'(x * 3 + y);
        v.u = $urandom;
        v.v = $urandom;
        return v;
    endfunction

    task automatic push(input vertex_t v);
        vbuf[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || tri_valid || rd_ptr != wr_ptr) && k < maxc) begin
            tick(1);
            k++;
        end
        tick(4);
        chk(tag, (k < maxc), 1'b1);
    endtask

    task automatic wait_cull(input string tag, input logic [15:0] target, input int maxc);
        int k;
        k = 0;
        while (cull_count != target && k < maxc) begin
            tick(1);
            k++;
        end
        chk(tag, cull_count, target);
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int k;
        k = 0;
        while (!tri_valid && k < maxc) begin
            tick(1);
            k++;
        end
        chk(tag, tri_valid, 1'b1);
    endtask

    // Observes the output side on falling edges: latency, hold stability, handoffs.
    task automatic monitor();
        logic         prev_valid;
        logic [319:0] prev_out, cur;
        int           ncyc, last_rd;
        tri_t         e;
        prev_valid = 1'b0;
        prev_out   = '0;
        ncyc       = 0;
        last_rd    = -100;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                prev_valid = 1'b0;
                continue;
            end
            if (fifo_read) begin
                last_rd = ncyc;
                chk("read_when_empty", fifo_empty, 1'b0);
            end
            if (tri_valid) begin
                cur = 320'({o_x, o_y, o_z, o_u, o_v});
                if (!prev_valid) chk("latency", ncyc - last_rd, 4);
                else             chk("hold_stable", cur, prev_out);
                chk("read_in_out", fifo_read, 1'b0);
                if (!raster_busy) begin
                    chk("tri_expected", (exp_q.size() > 0), 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("tri_x", o_x, e.x);
                        chk("tri_y", o_y, e.y);
                        chk("tri_z", o_z, e.z);
                        chk("tri_u", o_u, e.u);
                        chk("tri_v", o_v, e.v);
                        chk("tri_area", dut.u_cull.r_area, e.area);
                    end
                end
                prev_out = cur;
            end
            prev_valid = tri_valid;
        end
    endtask

    initial begin
        vertex_t a, b, c, d, f;
        int      seen, rdb;
        rst_n       = 1'b0;
        mode        = 2'd0;
        cull        = 2'd0;
        restart     = 1'b0;
        raster_busy = 1'b0;
        fork
            monitor();
        join_none

        // Reset with a vertex already waiting in the FIFO.
        tick(1);
        a = mkv(10, 10);
        push(a);
        tick(2);
        chk("rst_valid", tri_valid, 1'b0);
        chk("rst_read", fifo_read, 1'b0);
        chk("rst_x", o_x, 0);
        chk("rst_counts", {tri_count, cull_count}, 0);

        // List, counter-clockwise, cull CW: emitted.
        mode = 2'd0; cull = 2'd1; rst_n = 1'b1;
        b = mkv(50, 10); c = mkv(10, 50);
        push(b); push(c);
        exp_q.push_back(mk_tri(a, b, c));
        wait_idle("list_done", 100);
        chk("list_area", dut.u_cull.r_area, 1600);
        chk("list_tri_count", tri_count, 1);

        // List, reversed order: clockwise, culled.
        a = mkv(10, 10); b = mkv(10, 50); c = mkv(50, 10);
        push(a); push(b); push(c);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            tick(1);
            if (tri_valid) seen++;
        end
        chk("rev_no_valid", seen, 0);
        chk("rev_cull_count", cull_count, 1);

        // Collinear with cull CCW: degenerate, culled.
        cull = 2'd2;
        push(mkv(0, 0)); push(mkv(5, 5)); push(mkv(10, 10));
        wait_cull("colin_cull_count", 16'd2, 100);
        chk("colin_tri_count", tri_count, 1);

        // Strip of five vertices: three CCW triangles, middle one swapped.
        mode = 2'd1; cull = 2'd1;
        a = mkv(0, 0); b = mkv(10, 0); c = mkv(0, 10); d = mkv(10, 10); f = mkv(0, 20);
        push(a); push(b); push(c); push(d); push(f);
        exp_q.push_back(mk_tri(a, b, c));
        exp_q.push_back(mk_tri(c, b, d));
        exp_q.push_back(mk_tri(c, d, f));
        wait_idle("strip_done", 200);
        chk("strip_tri_count", tri_count, 4);
        chk("strip_cull_count", cull_count, 2);

        // Fan of four vertices: hub stays in slot 0.
        mode = 2'd2; cull = 2'd0;
        pulse_restart();
        a = mkv(0, 0); b = mkv(10, 0); c = mkv(10, 10); d = mkv(0, 10);
        push(a); push(b); push(c); push(d);
        exp_q.push_back(mk_tri(a, b, c));
        exp_q.push_back(mk_tri(a, c, d));
        wait_idle("fan_done", 200);
        chk("fan_tri_count", tri_count, 6);

        // Restart after two strip vertices: the next three start a fresh strip.
        mode = 2'd1; cull = 2'd0;
        pulse_restart();
        push(mkv(100, 100)); push(mkv(200, 50));
        tick(10);
        pulse_restart();
        a = mkv(0, 0); b = mkv(10, 0); c = mkv(0, 10);
        push(a); push(b); push(c);
        exp_q.push_back(mk_tri(a, b, c));
        wait_idle("restart_done", 100);
        chk("restart_tri_count", tri_count, 7);

        // Rasterizer busy: hold outputs, no reads, hand off on first free cycle.
        mode = 2'd0;
        pulse_restart();
        raster_busy = 1'b1;
        a = mkv(-20, -20); b = mkv(30, -5); c = mkv(-7, 40);
        push(a); push(b); push(c);
        exp_q.push_back(mk_tri(a, b, c));
        wait_valid("busy_valid", 50);
        a = mkv(1, 2);
        push(a);
        rdb = rd_ptr;
        tick(20);
        chk("busy_still_valid", tri_valid, 1'b1);
        chk("busy_no_reads", rd_ptr, rdb);
        chk("busy_tri_count", tri_count, 7);
        raster_busy = 1'b0;
        tick(1);
        chk("handoff_count", tri_count, 8);
        chk("handoff_valid_low", tri_valid, 1'b0);
        b = mkv(40, 2); c = mkv(1, 30);
        push(b); push(c);
        exp_q.push_back(mk_tri(a, b, c));
        wait_idle("after_busy_done", 100);
        chk("after_busy_count", tri_count, 9);

        // Reset while a triangle is held in OUT: dropped without handoff.
        raster_busy = 1'b1;
        a = mkv(0, 0); b = mkv(8, 0); c = mkv(0, 8);
        push(a); push(b); push(c);
        exp_q.push_back(mk_tri(a, b, c));
        wait_valid("rst_out_valid", 50);
        tick(3);
        rst_n = 1'b0;
        tick(2);
        void'(exp_q.pop_back());
        chk("rst_out_valid_low", tri_valid, 1'b0);
        chk("rst_out_counts", {tri_count, cull_count}, 0);
        chk("rst_out_x", o_x, 0);
        raster_busy = 1'b0;
        rst_n = 1'b1;
        tick(30);
        chk("post_rst_tri_count", tri_count, 0);
        chk("post_rst_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/primitive_assembler.md
PRIMITIVE_ASSEMBLER -- requirements
Module: primitive_assembler

Interface
REQ-001 Parameters SHALL be: XW 16, screen x/y width (signed); ZW 8, depth width; UVW 32, texture coordinate width; VW 2*XW+ZW+2*UVW, FIFO word width (104 by default).
REQ-002 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_fifo_data  in  VW  vertex word {x, y, z, u, v}, MSB first.
REQ-005 i_fifo_empty  in  1  vertex FIFO empty.
REQ-006 o_fifo_read  out  1  FIFO read strobe; data is valid the cycle after the strobe.
REQ-007 i_mode  in  2  0 list, 1 strip, 2 fan; 3 is treated as list.
REQ-008 i_cull  in  2  0 none, 1 cull CW, 2 cull CCW, 3 cull all non-degenerate.
REQ-009 i_restart  in  1  primitive restart pulse.
REQ-010 o_tri_valid  out  1  triangle available to the rasterizer.
REQ-011 i_raster_busy  in  1  rasterizer cannot accept a triangle.
REQ-012 o_x, o_y  out  3*XW each  signed vertex k at [k*XW +: XW].
REQ-013 o_z  out  3*ZW  vertex depths.
REQ-014 o_u, o_v  out  3*UVW each  texture coordinates.
REQ-015 o_tri_count, o_cull_count  out  16 each  emitted and culled triangle counters.

Function
REQ-016 The FSM SHALL have the states FETCH, LATCH, AREA, DECIDE and OUT.
- FETCH: assert o_fifo_read for one cycle when i_fifo_empty is 0, then go to LATCH.
- LATCH: write the vertex into the ring slot and increment the vertex count.
- When fewer vertices are held than the current mode needs, return to FETCH; otherwise go to AREA.
REQ-017 Vertex requirements per mode:
- List: needs 3 vertices; the count clears after each triangle.
- Strip: triangle n = (v[n], v[n+1], v[n+2]); on odd n the block SHALL swap output slots 0 and 1 to preserve winding.
- Fan: (v0, v[n+1], v[n+2]), with v0 held until restart.
REQ-018 i_mode SHALL be sampled only while the vertex count is 0.
REQ-019 AREA SHALL register the signed area A = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0) at 2*XW+3 bits, using the output-ordered vertices.
REQ-020 Sign convention: A>0 is CCW, A<0 is CW.
REQ-021 In DECIDE, A==0 SHALL be culled whenever i_cull != 0.
REQ-022 A culled triangle SHALL increment o_cull_count and return to FETCH without asserting o_tri_valid.
REQ-023 Latency: o_tri_valid SHALL rise exactly 3 cycles after the LATCH cycle of the completing vertex.
REQ-024 Output hold: in OUT, o_tri_valid and all vertex outputs SHALL stay stable until a cycle where o_tri_valid=1 and i_raster_busy=0.
REQ-025 Handoff: in that handoff cycle o_tri_count SHALL increment; o_tri_valid SHALL be 0 on the next cycle and the FSM SHALL return to FETCH.
REQ-026 o_fifo_read SHALL never be asserted outside FETCH, and never while i_fifo_empty=1.
REQ-027 A restart in OUT, AREA or DECIDE SHALL be recorded and applied after that triangle completes or is culled; a restart in FETCH or LATCH SHALL apply immediately. Applying a restart clears the vertex count and the strip parity, and drops any partial vertex.
REQ-028 Both counters SHALL wrap from 0xFFFF to 0.
REQ-029 All arithmetic SHALL be signed and sign-extended before subtraction; overflow is impossible at the stated width.

Reset
REQ-030 While i_rst_n=0 at a clock edge, the block SHALL enter FETCH and clear the vertex count, strip parity, pending restart and both counters.
REQ-031 During reset, o_tri_valid, o_fifo_read and every vertex output SHALL be 0.
REQ-032 A reset asserted in OUT SHALL drop the pending triangle without a handoff.

Structure
REQ-033 A shared package raster_pkg SHALL hold the default XW/ZW/UVW values, the mode and cull enums, and the vertex struct.
REQ-034 Area computation SHALL live in one sub-module, cull_unit: registered signed area plus a cull decision output.

Verification
REQ-035 List mode, cull=1, vertices (10,10), (50,10), (10,50) -> A=1600, o_tri_valid 3 cycles after the third LATCH, outputs match inputs, o_tri_count=1.
REQ-036 List mode, cull=1, reversed order (10,10), (10,50), (50,10) -> no o_tri_valid within 200 cycles, o_cull_count=1.
REQ-037 Strip mode, cull=1, 5 vertices with consistent geometry -> 3 triangles emitted; the 2nd has slots 0 and 1 swapped; all have A>0.
REQ-038 Fan mode, 4 vertices -> 2 triangles, both with slot 0 = first vertex.
REQ-039 i_raster_busy=1 for 20 cycles while o_tri_valid -> outputs stable, no FIFO reads, handoff on the first cycle busy=0.
REQ-040 Collinear (0,0), (5,5), (10,10) with cull=2 -> culled; restart mid-strip after 2 vertices -> next 3 vertices form a fresh triangle.
